// File: rtl/game_ctrl_pkg.sv
// Shared types and default constants for the multi-level game controller.
// Build option: define GAME_PAUSE_EN to add the PAUSED state and pause I/O.
package game_ctrl_pkg;

  localparam int DEF_LEVELS            = 3;
  localparam int DEF_LEVEL_W           = 2;
  localparam int DEF_LIVES             = 3;
  localparam int DEF_LIVES_W           = 2;
  localparam int DEF_SCORE_W           = 4;
  localparam int DEF_WIN_SCORE         = 12;
  localparam int DEF_FRUIT_W           = 4;
  localparam int DEF_FRUITS_PER_LEVEL  = 10;
  localparam int DEF_INTERLEVEL_FRAMES = 60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GOT_KEY,
    ST_LEVEL_DONE,
    ST_GAME_OVER,
    ST_WIN
`ifdef GAME_PAUSE_EN
    ,
    ST_PAUSED
`endif
  } game_state_t;

  // Width of a counter that must hold 0 .. frames-1 (at least one bit).
  function automatic int frame_cnt_width(input int frames);
    return (frames < 2) ? 1 : $clog2(frames);
  endfunction

endpackage

// File: rtl/level_game_controller_if.sv
// Signal bundle between the game controller and the keyboard/timer/counter
// blocks (inputs) and the screen-mux/object blocks (outputs).
// Build option: GAME_PAUSE_EN adds pauseIsPressed and pausedEnable.
interface level_game_controller_if
  import game_ctrl_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W,
  parameter int LIVES_W = DEF_LIVES_W,
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int FRUIT_W = DEF_FRUIT_W
);

  // Inputs to the controller
  logic               startOfFrame;
  logic               enterIsPressed;
  logic               timer_end;
  logic [LIVES_W-1:0] livesCounter;
  logic [SCORE_W-1:0] scoreCounter;
  logic [FRUIT_W-1:0] fruitsCounter;
  logic               key_collision;
  logic               hit_request;

  // Outputs from the controller
  logic               startGameEnable;
  logic               GameOverEnable;
  logic               winGameEnable;
  logic               levelDoneEnable;
  logic               game_on;
  logic               got_key;
  logic [LEVEL_W-1:0] level;
  logic               newLevelPulse;
  logic               SingleHitPulse;

`ifdef GAME_PAUSE_EN
  logic               pauseIsPressed;
  logic               pausedEnable;
`endif

  // Environment side: drives game inputs, observes screen selects.
  modport master (
`ifdef GAME_PAUSE_EN
    output pauseIsPressed,
    input  pausedEnable,
`endif
    output startOfFrame, enterIsPressed, timer_end, livesCounter,
    output scoreCounter, fruitsCounter, key_collision, hit_request,
    input  startGameEnable, GameOverEnable, winGameEnable, levelDoneEnable,
    input  game_on, got_key, level, newLevelPulse, SingleHitPulse
  );

  // Controller side.
  modport slave (
`ifdef GAME_PAUSE_EN
    input  pauseIsPressed,
    output pausedEnable,
`endif
    input  startOfFrame, enterIsPressed, timer_end, livesCounter,
    input  scoreCounter, fruitsCounter, key_collision, hit_request,
    output startGameEnable, GameOverEnable, winGameEnable, levelDoneEnable,
    output game_on, got_key, level, newLevelPulse, SingleHitPulse
  );

endinterface

// File: rtl/level_game_controller_rise_edge_detect.sv
// Rising-edge detector for keyboard level signals: a held key yields a
// single one-cycle pulse.
module rise_edge_detect (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);

  logic in_d;

  // Delay the input by one cycle to compare against the present value.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order between blocks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) in_d <= 1'b0;
    else         in_d <= in;
  end

  assign pulse = in & ~in_d;

endmodule

// File: rtl/level_game_controller.sv
// Multi-level game sequencer: idle, play, key-collected, level-done, game
// over and win screens across LEVELS levels, with a one-per-frame hit pulse
// and a new-level pulse for clearing level-scoped counters.
// Build option: define GAME_PAUSE_EN for the pause key and PAUSED screen.
module level_game_controller
  import game_ctrl_pkg::*;
#(
  parameter int LEVELS            = DEF_LEVELS,
  parameter int LEVEL_W           = DEF_LEVEL_W,
  parameter int LIVES             = DEF_LIVES,
  parameter int LIVES_W           = DEF_LIVES_W,
  parameter int SCORE_W           = DEF_SCORE_W,
  parameter int WIN_SCORE         = DEF_WIN_SCORE,
  parameter int FRUIT_W           = DEF_FRUIT_W,
  parameter int FRUITS_PER_LEVEL  = DEF_FRUITS_PER_LEVEL,
  parameter int INTERLEVEL_FRAMES = DEF_INTERLEVEL_FRAMES
) (
  input logic                     clk,
  input logic                     resetN,
  level_game_controller_if.slave  game
);

  localparam int FRAME_W = frame_cnt_width(INTERLEVEL_FRAMES);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(LEVELS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(INTERLEVEL_FRAMES - 1);

  game_state_t        state_q;
  logic [LEVEL_W-1:0] level_q;
  logic [FRAME_W-1:0] frame_cnt;
  logic               new_level_q;
  logic               hit_flag;
  logic               hit_pulse_q;

  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic [FRUIT_W-1:0] fruits;
  logic               enter_edge;
  logic               lose;
  logic               score_ok;

  logic start_en, over_en, win_en, done_en, on, have_key;

  assign lives  = game.livesCounter;
  assign score  = game.scoreCounter;
  assign fruits = game.fruitsCounter;

  rise_edge_detect u_enter_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (game.enterIsPressed),
    .pulse  (enter_edge)
  );

`ifdef GAME_PAUSE_EN
  game_state_t saved_q;
  logic        pause_edge;
  logic        paused_en;

  rise_edge_detect u_pause_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (game.pauseIsPressed),
    .pulse  (pause_edge)
  );
`endif

  // Out of lives, out of time, or all fruits spent without reaching the
  // target score all end the game.
  assign score_ok = int'(score) >= WIN_SCORE;
  assign lose     = (int'(lives) >= LIVES) || game.timer_end ||
                    (!score_ok && (int'(fruits) >= FRUITS_PER_LEVEL));

  // Game sequencer: state, level index, level-done dwell and new-level pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_IDLE;
      level_q     <= '0;
      frame_cnt   <= '0;
      new_level_q <= 1'b0;
`ifdef GAME_PAUSE_EN
      saved_q     <= ST_PLAY;
`endif
    end else begin
      new_level_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (enter_edge) begin
            state_q     <= ST_PLAY;
            level_q     <= '0;
            new_level_q <= 1'b1;
          end
        end
        ST_PLAY: begin
`ifdef GAME_PAUSE_EN
          if (pause_edge) begin
            saved_q <= ST_PLAY;
            state_q <= ST_PAUSED;
          end else
`endif
          if (lose)                    state_q <= ST_GAME_OVER;
          else if (game.key_collision) state_q <= ST_GOT_KEY;
        end
        ST_GOT_KEY: begin
`ifdef GAME_PAUSE_EN
          if (pause_edge) begin
            saved_q <= ST_GOT_KEY;
            state_q <= ST_PAUSED;
          end else
`endif
          // Reaching the score with the key beats a simultaneous lose.
          if (score_ok) begin
            frame_cnt <= '0;
            state_q   <= (level_q == LAST_LEVEL) ? ST_WIN : ST_LEVEL_DONE;
          end else if (lose) begin
            state_q <= ST_GAME_OVER;
          end
        end
        ST_LEVEL_DONE: begin
          // Only frames seen while on this screen count toward the dwell.
          if (game.startOfFrame) begin
            if (frame_cnt == LAST_FRAME) begin
              frame_cnt   <= '0;
              level_q     <= level_q + LEVEL_W'(1);
              new_level_q <= 1'b1;
              state_q     <= ST_PLAY;
            end else begin
              frame_cnt <= frame_cnt + FRAME_W'(1);
            end
          end
        end
        ST_GAME_OVER, ST_WIN: begin
          if (enter_edge) begin
            state_q <= ST_IDLE;
            level_q <= '0;
          end
        end
`ifdef GAME_PAUSE_EN
        ST_PAUSED: begin
          // Enter and the lose condition are ignored until un-paused.
          if (pause_edge) state_q <= saved_q;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Screen selects and play flags decoded from the present state.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    start_en = 1'b0;
    over_en  = 1'b0;
    win_en   = 1'b0;
    done_en  = 1'b0;
    on       = 1'b0;
    have_key = 1'b0;
`ifdef GAME_PAUSE_EN
    paused_en = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE:       start_en = 1'b1;
      ST_PLAY:       on       = 1'b1;
      ST_GOT_KEY: begin
        on       = 1'b1;
        have_key = 1'b1;
      end
      ST_LEVEL_DONE: done_en  = 1'b1;
      ST_GAME_OVER:  over_en  = 1'b1;
      ST_WIN:        win_en   = 1'b1;
`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        paused_en = 1'b1;
        have_key  = (saved_q == ST_GOT_KEY);
      end
`endif
      default:       start_en = 1'b1;
    endcase
  end

  // One hit pulse per frame during gameplay; a frame start in the same
  // cycle as the request re-arms immediately.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_flag    <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else if (!on) begin
      hit_flag    <= 1'b0;
      hit_pulse_q <= 1'b0;
    end else if (game.hit_request && (!hit_flag || game.startOfFrame)) begin
      hit_flag    <= 1'b1;
      hit_pulse_q <= 1'b1;
    end else begin
      hit_pulse_q <= 1'b0;
      if (game.startOfFrame) hit_flag <= 1'b0;
    end
  end

  assign game.startGameEnable = start_en;
  assign game.GameOverEnable  = over_en;
  assign game.winGameEnable   = win_en;
  assign game.levelDoneEnable = done_en;
  assign game.game_on         = on;
  assign game.got_key         = have_key;
  assign game.level           = level_q;
  assign game.newLevelPulse   = new_level_q;
  assign game.SingleHitPulse  = hit_pulse_q;
`ifdef GAME_PAUSE_EN
  assign game.pausedEnable    = paused_en;
`endif

endmodule

// File: tb/tb_level_game_controller.sv
// Self-checking bench for level_game_controller: directed scenarios followed
// by randomized play, all compared every cycle against a screen-level model.
module tb_level_game_controller;

  localparam int LEVELS            = 3;
  localparam int LEVEL_W           = 2;
  localparam int LIVES             = 3;
  localparam int LIVES_W           = 2;
  localparam int SCORE_W           = 4;
  localparam int WIN_SCORE         = 12;
  localparam int FRUIT_W           = 4;
  localparam int FRUITS_PER_LEVEL  = 10;
  localparam int INTERLEVEL_FRAMES = 60;

  typedef enum {M_START, M_PLAYING, M_HAVE_KEY, M_BETWEEN, M_OVER, M_WON, M_PAUSED} screen_t;

  logic clk;
  logic resetN;

  level_game_controller_if #(
    .LEVEL_W(LEVEL_W), .LIVES_W(LIVES_W), .SCORE_W(SCORE_W), .FRUIT_W(FRUIT_W)
  ) gif ();

  level_game_controller #(
    .LEVELS(LEVELS), .LEVEL_W(LEVEL_W), .LIVES(LIVES), .LIVES_W(LIVES_W),
    .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .FRUIT_W(FRUIT_W),
    .FRUITS_PER_LEVEL(FRUITS_PER_LEVEL), .INTERLEVEL_FRAMES(INTERLEVEL_FRAMES)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .game   (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  screen_t m_screen;
  screen_t m_saved;
  int      m_level;
  int      m_frames;
  bit      m_enter_prev;
  bit      m_pause_prev;
  bit      m_hit_used;
  bit      m_hit_out;
  bit      m_new_out;

  int n_assert;
  int n_fail;
  int hit_seen;
  int nlp_seen;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_screen     = M_START;
    m_saved      = M_PLAYING;
    m_level      = 0;
    m_frames     = 0;
    m_enter_prev = 0;
    m_pause_prev = 0;
    m_hit_used   = 0;
    m_hit_out    = 0;
    m_new_out    = 0;
  endtask

  task automatic check_outputs(input string tag);
    bit playing;
    playing = (m_screen == M_PLAYING) || (m_screen == M_HAVE_KEY);
    check({tag, ".start"},  gif.startGameEnable, m_screen == M_START);
    check({tag, ".over"},   gif.GameOverEnable,  m_screen == M_OVER);
    check({tag, ".win"},    gif.winGameEnable,   m_screen == M_WON);
    check({tag, ".done"},   gif.levelDoneEnable, m_screen == M_BETWEEN);
    check({tag, ".on"},     gif.game_on,         playing);
    check({tag, ".key"},    gif.got_key,
          (m_screen == M_HAVE_KEY) || (m_screen == M_PAUSED && m_saved == M_HAVE_KEY));
    check({tag, ".level"},  gif.level,           m_level);
    check({tag, ".newlvl"}, gif.newLevelPulse,   m_new_out);
    check({tag, ".hit"},    gif.SingleHitPulse,  m_hit_out);
`ifdef GAME_PAUSE_EN
    check({tag, ".paused"}, gif.pausedEnable,    m_screen == M_PAUSED);
`endif
  endtask

  // One clock: predict the screen after this edge from the present inputs,
  // advance the clock, then compare.
  task automatic tick(input string tag = "cyc");
    bit enter, pause, enter_rise, pause_rise, lost, playing, hit_now;
    screen_t nxt;
    int      nxt_level, nxt_frames;
    bit      nxt_new;
    screen_t nxt_saved;
    bit      nxt_used;

    enter = gif.enterIsPressed;
`ifdef GAME_PAUSE_EN
    pause = gif.pauseIsPressed;
`else
    pause = 1'b0;
`endif
    enter_rise = enter && !m_enter_prev;
    pause_rise = pause && !m_pause_prev;
    lost = (gif.livesCounter >= LIVES) || gif.timer_end ||
           ((gif.scoreCounter < WIN_SCORE) && (gif.fruitsCounter >= FRUITS_PER_LEVEL));
    playing = (m_screen == M_PLAYING) || (m_screen == M_HAVE_KEY);

    // A hit is granted if none was granted yet this frame, or this cycle starts a frame.
    hit_now  = playing && gif.hit_request && (!m_hit_used || gif.startOfFrame);
    nxt_used = playing && (hit_now || (m_hit_used && !gif.startOfFrame));

    nxt = m_screen; nxt_level = m_level; nxt_frames = m_frames;
    nxt_new = 0; nxt_saved = m_saved;
    case (m_screen)
      M_START: if (enter_rise) begin nxt = M_PLAYING; nxt_level = 0; nxt_new = 1; end
      M_PLAYING: begin
        if (pause_rise) begin nxt_saved = M_PLAYING; nxt = M_PAUSED; end
        else if (lost) nxt = M_OVER;
        else if (gif.key_collision) nxt = M_HAVE_KEY;
      end
      M_HAVE_KEY: begin
        if (pause_rise) begin nxt_saved = M_HAVE_KEY; nxt = M_PAUSED; end
        else if (gif.scoreCounter >= WIN_SCORE) begin
          nxt = (m_level == LEVELS - 1) ? M_WON : M_BETWEEN;
          nxt_frames = 0;
        end else if (lost) nxt = M_OVER;
      end
      M_BETWEEN: if (gif.startOfFrame) begin
        nxt_frames = m_frames + 1;
        if (nxt_frames == INTERLEVEL_FRAMES) begin
          nxt_frames = 0; nxt_level = m_level + 1; nxt_new = 1; nxt = M_PLAYING;
        end
      end
      M_OVER, M_WON: if (enter_rise) begin nxt = M_START; nxt_level = 0; end
      M_PAUSED: if (pause_rise) nxt = m_saved;
      default: ;
    endcase

    @(posedge clk);
    #1;
    if (!resetN) begin
      model_reset();
    end else begin
      m_screen = nxt; m_level = nxt_level; m_frames = nxt_frames;
      m_new_out = nxt_new; m_saved = nxt_saved; m_hit_used = nxt_used;
      m_hit_out = hit_now; m_enter_prev = enter; m_pause_prev = pause;
    end
    if (gif.SingleHitPulse) hit_seen++;
    if (gif.newLevelPulse)  nlp_seen++;
    check_outputs(tag);
  endtask

  task automatic frame(input int len);
    gif.startOfFrame = 1'b1;
    tick("frm");
    gif.startOfFrame = 1'b0;
    repeat (len - 1) tick("frm");
  endtask

  task automatic press_enter();
    gif.enterIsPressed = 1'b1;
    tick("ent");
    gif.enterIsPressed = 1'b0;
    tick("ent");
  endtask

  // From PLAY: collect the key, then reach the winning score.
  task automatic clear_level();
    gif.key_collision = 1'b1;
    tick("key");
    gif.key_collision = 1'b0;
    check("got_key_state", gif.got_key, 1'b1);
    gif.scoreCounter = SCORE_W'(WIN_SCORE);
    tick("score");
    gif.scoreCounter = '0;
  endtask

  task automatic dwell_level_done(input int exp_level);
    nlp_seen = 0;
    repeat (INTERLEVEL_FRAMES - 1) frame(3);
    check("dwell_not_done", gif.levelDoneEnable, 1'b1);
    frame(3);
    check("dwell_back_play", gif.game_on, 1'b1);
    check("dwell_level", gif.level, exp_level);
    check("dwell_newlvl_count", nlp_seen, 1);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; hit_seen = 0; nlp_seen = 0;
    resetN = 1'b0;
    gif.startOfFrame = 1'b0; gif.enterIsPressed = 1'b0; gif.timer_end = 1'b0;
    gif.livesCounter = '0; gif.scoreCounter = '0; gif.fruitsCounter = '0;
    gif.key_collision = 1'b0; gif.hit_request = 1'b0;
`ifdef GAME_PAUSE_EN
    gif.pauseIsPressed = 1'b0;
`endif
    model_reset();
    repeat (3) tick("rst");
    check("reset_start", gif.startGameEnable, 1'b1);
    resetN = 1'b1;
    tick("idle");

    // Enter held for 10 cycles starts exactly one game.
    nlp_seen = 0;
    gif.enterIsPressed = 1'b1;
    repeat (10) tick("hold");
    gif.enterIsPressed = 1'b0;
    check("hold_one_newlvl", nlp_seen, 1);
    check("hold_in_play", gif.game_on, 1'b1);
    check("hold_level0", gif.level, 0);

    // Hit held across three frames gives exactly three pulses.
    hit_seen = 0;
    gif.hit_request = 1'b1;
    tick("hit"); tick("hit");
    frame(4); frame(4);
    gif.hit_request = 1'b0;
    tick("hit");
    check("hit_three", hit_seen, 3);

    // Key and out-of-lives in the same cycle: losing wins.
    gif.key_collision = 1'b1; gif.livesCounter = LIVES_W'(3);
    tick("klose");
    gif.key_collision = 1'b0; gif.livesCounter = '0;
    check("lose_over_key", gif.GameOverEnable, 1'b1);
    press_enter();
    check("over_to_idle", gif.startGameEnable, 1'b1);

    // No hit pulses outside gameplay.
    hit_seen = 0;
    gif.hit_request = 1'b1;
    frame(3); frame(3); frame(3);
    gif.hit_request = 1'b0;
    check("hit_idle_none", hit_seen, 0);

    // Play through all levels to the win screen.
    press_enter();
    clear_level();
    check("lvl0_done", gif.levelDoneEnable, 1'b1);
    dwell_level_done(1);
    clear_level();
    dwell_level_done(2);
    clear_level();
    check("win_screen", gif.winGameEnable, 1'b1);
    check("win_level", gif.level, LEVELS - 1);
    press_enter();
    check("win_to_idle", gif.startGameEnable, 1'b1);
    check("win_idle_level", gif.level, 0);

`ifdef GAME_PAUSE_EN
    // Pause in GOT_KEY masks an expired timer until resumed.
    press_enter();
    gif.key_collision = 1'b1; tick("pk"); gif.key_collision = 1'b0;
    gif.pauseIsPressed = 1'b1; tick("pz"); gif.pauseIsPressed = 1'b0;
    gif.timer_end = 1'b1;
    repeat (5) tick("pz");
    check("paused_hold", gif.pausedEnable, 1'b1);
    check("paused_key", gif.got_key, 1'b1);
    gif.pauseIsPressed = 1'b1; tick("pz");
    check("resume_key", gif.got_key, 1'b1);
    gif.pauseIsPressed = 1'b0; tick("pz");
    check("resume_lose", gif.GameOverEnable, 1'b1);
    gif.timer_end = 1'b0;
    press_enter();
`endif

    // Asynchronous reset mid-game returns to the start screen at once.
    press_enter();
    check("pre_reset_play", gif.game_on, 1'b1);
    #2 resetN = 1'b0;
    #1;
    check("async_rst_start", gif.startGameEnable, 1'b1);
    check("async_rst_on", gif.game_on, 1'b0);
    model_reset();
    tick("rst");
    resetN = 1'b1;
    tick("idle");

    // Randomized play against the model.
    for (int i = 0; i < 3000; i++) begin
      gif.startOfFrame   = ($urandom_range(0, 3) == 0);
      gif.enterIsPressed = ($urandom_range(0, 7) == 0);
      gif.timer_end      = ($urandom_range(0, 39) == 0);
      gif.key_collision  = ($urandom_range(0, 9) == 0);
      gif.hit_request    = ($urandom_range(0, 2) == 0);
      gif.livesCounter   = ($urandom_range(0, 15) == 0) ? LIVES_W'(3) : LIVES_W'($urandom_range(0, 2));
      gif.scoreCounter   = SCORE_W'($urandom_range(0, 15));
      gif.fruitsCounter  = FRUIT_W'($urandom_range(0, 11));
`ifdef GAME_PAUSE_EN
      gif.pauseIsPressed = ($urandom_range(0, 19) == 0);
`endif
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/level_game_controller.md
# level_game_controller

Parametrised multi-level successor to the single-level game FSM: sequences idle, play, key-collected, inter-level and end screens across `LEVELS` levels and restarts on Enter after game over or win. Sits between the keyboard/timer/counter blocks and the screen-mux and object blocks of the VGA top level. Supplies the enables that select start, game-over, win and level-done screens, plus one-per-frame hit and new-level pulses.

## Interface
- `LEVELS`, 3: number of levels; win after the last.
- `LEVEL_W`, 2: width of `level`; must satisfy `LEVELS <= 2**LEVEL_W`.
- `LIVES`, 3: lives-lost count that ends the game.
- `LIVES_W`, 2: width of `livesCounter`.
- `SCORE_W`, 4: width of `scoreCounter`.
- `WIN_SCORE`, 12: score needed, with key held, to clear a level.
- `FRUIT_W`, 4: width of `fruitsCounter`.
- `FRUITS_PER_LEVEL`, 10: fruits spawned per level.
- `INTERLEVEL_FRAMES`, 60: frames shown on the level-done screen; minimum 1.
- `clk` in 1: system clock; only clock.
- `resetN` in 1: asynchronous, active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `enterIsPressed` in 1: level signal from keyboard.
- `timer_end` in 1: level timer expired.
- `livesCounter` in LIVES_W: lives lost.
- `scoreCounter` in SCORE_W: current level score.
- `fruitsCounter` in FRUIT_W: fruits spawned this level.
- `key_collision` in 1: player touched key.
- `hit_request` in 1: raw player/hazard collision.
- `pauseIsPressed` in 1: keyboard level signal; present only with `GAME_PAUSE_EN`.
- `startGameEnable`, `GameOverEnable`, `winGameEnable`, `levelDoneEnable` out 1: screen selects.
- `game_on` out 1: gameplay active.
- `got_key` out 1: key held this level.
- `pausedEnable` out 1: paused screen select; present only with `GAME_PAUSE_EN`.
- `level` out LEVEL_W: current level, 0-based.
- `newLevelPulse` out 1: one cycle at each level start, so level-scoped counters can clear.
- `SingleHitPulse` out 1: at most one pulse per frame.

## Operation
- **Edge detection.** Enter and pause act on rising edges only: `x & ~x_d`, with `x_d` registered. A held key triggers once.
- **Lose condition.** `lose = livesCounter >= LIVES || timer_end || (scoreCounter < WIN_SCORE && fruitsCounter >= FRUITS_PER_LEVEL)`.
- **States.**
  - IDLE: `startGameEnable=1`. On enter edge: go to PLAY, `newLevelPulse=1`, `level=0`.
  - PLAY: `game_on=1`. `lose` goes to GAME_OVER. Otherwise, `key_collision` goes to GOT_KEY. When both occur in the same cycle, `lose` wins.
  - GOT_KEY: `game_on=1`, `got_key=1`.
    - `scoreCounter >= WIN_SCORE` goes to WIN if `level == LEVELS-1`, otherwise to LEVEL_DONE.
    - Otherwise `lose` goes to GAME_OVER. A win beats a simultaneous lose.
  - LEVEL_DONE: `levelDoneEnable=1`. A frame counter increments on each `startOfFrame`. When the counter reaches `INTERLEVEL_FRAMES`: clear the counter, `level++`, `newLevelPulse=1`, go to PLAY.
  - GAME_OVER: `GameOverEnable=1`. Enter edge goes to IDLE with `level=0`.
  - WIN: `winGameEnable=1`. Enter edge goes to IDLE with `level=0`.
- **Screen outputs.** Screen enables, `game_on` and `got_key` are combinational decodes of the present state. Exactly one screen enable is high, except while `game_on=1`.
- **Hit pulse.**
  - A per-frame flag is cleared on `startOfFrame`.
  - `SingleHitPulse` (registered) fires on `hit_request` only when `game_on=1` and the flag is clear, then sets the flag.
  - If `startOfFrame` and `hit_request` occur in the same cycle, the pulse is allowed.
  - Outside `game_on`, the flag is held clear.

## Timing
- Reset values: present state IDLE, so `startGameEnable=1`. All other outputs 0, `level=0`, counters 0, edge registers 0.
- Reset mid-game returns to IDLE asynchronously.
- An input sampled at edge N changes state at N+1. Decoded outputs are valid in the cycle after that edge.
- `SingleHitPulse` and `newLevelPulse` are registered and last exactly 1 cycle, asserted in the cycle after the triggering edge.
- Level-done dwell is exactly `INTERLEVEL_FRAMES` `startOfFrame` pulses. A pulse in the entry cycle does not count.
- `level` never exceeds `LEVELS-1`. Increment cannot wrap, because the last level exits to WIN.

## Configuration
- `GAME_PAUSE_EN` defined:
  - Adds the `pauseIsPressed` port, the `pausedEnable` output and a PAUSED state.
  - A pause edge in PLAY or GOT_KEY saves the state and enters PAUSED: `pausedEnable=1`, `game_on=0`, `got_key` held.
  - The next pause edge returns to the saved state. Enter is ignored while paused.
  - `lose` is not evaluated while paused.
- `GAME_PAUSE_EN` undefined: no such ports or state; pause logic is absent.

## Structure
- `game_ctrl_pkg` holds:
  - the state enum (IDLE, PLAY, GOT_KEY, LEVEL_DONE, GAME_OVER, WIN, plus PAUSED under the macro);
  - default parameter constants.
- One sub-module, `rise_edge_detect`: clk, resetN, in, pulse. Instantiated for enter and for pause.

## Test plan
- Enter held 10 cycles from IDLE -> one transition to PLAY. `newLevelPulse` high 1 cycle, `level=0`.
- PLAY with `key_collision` and `livesCounter=3` in the same cycle -> GAME_OVER. Later Enter edge -> IDLE.
- GOT_KEY with `scoreCounter=12` at `level=0` -> LEVEL_DONE. After 60 `startOfFrame` pulses: `level=1`, one `newLevelPulse`, PLAY.
- `level=2` with `LEVELS=3`, then key and `score=12` -> WIN. Enter edge -> IDLE, `level=0`.
- `hit_request` held across 3 frames in PLAY -> exactly 3 `SingleHitPulse` cycles. `hit_request` in IDLE -> none.
- With `GAME_PAUSE_EN`: pause in GOT_KEY with `timer_end=1` while paused -> stays PAUSED. Second pause edge -> GOT_KEY, then GAME_OVER next cycle.
